// File: rtl/mem_stage_seq.sv
// mem_stage_seq: handshaked pipeline memory stage.
// Owns the data RAM, the downward-growing stack pointer and the EPC. Performs
// 16-bit (one beat) or 32-bit (two beat) loads/stores, stack push/pop and PC
// push behind a valid/ready handshake. Faults (invalid address, stack
// overflow/underflow) squash the access and the writeback, and the first one
// is recorded in o_exc/o_epc until cleared.
//
// Ports:
//   clk, i_reset      rising-edge clock, synchronous active-high reset
//   i_valid/o_ready   request handshake (accept = i_valid & o_ready)
//   i_op, i_sp_op     access kind: op 00 none/01 load/10 store; sp_op 01 push/10 pop
//   i_push_pc, i_en32 push i_pc+1 (forces 32-bit) / 32-bit access
//   i_wb, i_alu_data  forwarded controls / address or pass-through value
//   i_wdata, i_pc     store data / PC of the instruction
//   i_epc_clr         clear o_exc and o_epc
//   o_valid           one-cycle result pulse
//   o_wb, o_alu_data  forwarded values (o_wb zero on fault)
//   o_mem_data        load/pop result {hi,lo}, zero-extended for 16-bit
//   o_sp, o_exc, o_epc stack pointer, sticky cause, faulting PC
module mem_stage_seq #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned SP_INIT  = (1 << ADDR_W) - 1,
  parameter int unsigned SP_LIMIT = 1 << (ADDR_W - 1)
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_op,
  input  logic [1:0]        i_sp_op,
  input  logic              i_push_pc,
  input  logic              i_en32,
  input  logic [1:0]        i_wb,
  input  logic [DATA_W-1:0] i_alu_data,
  input  logic [31:0]       i_wdata,
  input  logic [31:0]       i_pc,
  input  logic              i_epc_clr,
  output logic              o_valid,
  output logic [1:0]        o_wb,
  output logic [DATA_W-1:0] o_alu_data,
  output logic [31:0]       o_mem_data,
  output logic [ADDR_W-1:0] o_sp,
  output logic [1:0]        o_exc,
  output logic [31:0]       o_epc
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam int unsigned SpW   = ADDR_W + 1;
  localparam logic [SpW-1:0]    SpInitX = SpW'(SP_INIT);
  localparam logic [SpW-1:0]    SpLimM1 = SpW'(SP_LIMIT - 1);
  localparam logic [ADDR_W-1:0] AddrMax = '1;

  typedef enum logic [0:0] {StIdle, StBeat1} state_e;

  state_e r_state, w_state_nxt;

  logic [DATA_W-1:0] r_mem [Depth];

  logic              r_valid;
  logic [1:0]        r_wb;
  logic [DATA_W-1:0] r_alu_data;
  logic [31:0]       r_mem_data;
  logic [ADDR_W-1:0] r_sp;
  logic [1:0]        r_exc;
  logic [31:0]       r_epc;
  // Second-beat context captured at accept.
  logic              r_is_load;
  logic              r_is_store;
  logic [DATA_W-1:0] r_lo;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_hi_wdata;
  logic [1:0]        r_wb_hold;
  logic [DATA_W-1:0] r_alu_hold;

  logic              w_accept, w_is_push, w_is_pop, w_is_stack;
  logic              w_is_load, w_is_store, w_access, w_is32;
  logic              w_ovf, w_unf, w_inv, w_fault, w_go_beat1;
  logic [1:0]        w_exc_code;
  logic [SpW-1:0]    w_n, w_sp_dec, w_sp_inc;
  logic [ADDR_W-1:0] w_base, w_rd_addr, w_mem_waddr;
  logic [DATA_W-1:0] w_rd_data, w_mem_wdata;
  logic [31:0]       w_store_data;
  logic              w_mem_we;

  assign o_ready    = (r_state == StIdle);
  assign w_accept   = i_valid & o_ready;

  // Decode; an illegal i_sp_op of 11 falls through as a plain data access.
  assign w_is_push  = (i_sp_op == 2'b01);
  assign w_is_pop   = (i_sp_op == 2'b10);
  assign w_is_stack = w_is_push | w_is_pop;
  assign w_is_load  = w_is_pop  | (!w_is_stack && i_op == 2'b01);
  assign w_is_store = w_is_push | (!w_is_stack && i_op == 2'b10);
  assign w_access   = w_is_load | w_is_store;
  assign w_is32     = i_en32 | (w_is_push & i_push_pc);
  assign w_store_data = i_push_pc ? (i_pc + 32'd1) : i_wdata;

  // One extra bit so that limit checks see the true value before wrapping.
  assign w_n      = w_is32 ? SpW'(2) : SpW'(1);
  assign w_sp_dec = {1'b0, r_sp} - w_n;
  assign w_sp_inc = {1'b0, r_sp} + w_n;

  always_comb begin
    w_base = i_alu_data[ADDR_W-1:0];
    if (w_is_push) begin
      w_base = w_is32 ? (r_sp - ADDR_W'(1)) : r_sp;
    end else if (w_is_pop) begin
      w_base = r_sp + ADDR_W'(1);
    end
  end

  assign w_ovf = w_is_push & (w_sp_dec < SpLimM1);
  assign w_unf = w_is_pop  & (w_sp_inc > SpInitX);
  assign w_inv = !w_is_stack & w_access &
                 (((i_alu_data >> ADDR_W) != '0) || (w_is32 && w_base == AddrMax));

  always_comb begin
    w_exc_code = 2'b00;
    if (w_ovf) begin
      w_exc_code = 2'b10;
    end else if (w_unf) begin
      w_exc_code = 2'b11;
    end else if (w_inv) begin
      w_exc_code = 2'b01;
    end
  end

  assign w_fault    = (w_exc_code != 2'b00);
  assign w_go_beat1 = w_accept & w_access & w_is32 & !w_fault;

  // RAM: lo word written at accept, hi word in the second beat. Gated by reset
  // so an aborted second beat never writes.
  assign w_mem_we = !i_reset &&
                    ((w_accept && w_is_store && !w_fault) ||
                     (r_state == StBeat1 && r_is_store));
  assign w_mem_waddr = (r_state == StBeat1) ? r_addr : w_base;
  assign w_mem_wdata = (r_state == StBeat1) ? r_hi_wdata : w_store_data[DATA_W-1:0];
  assign w_rd_addr   = (r_state == StBeat1) ? r_addr : w_base;
  assign w_rd_data   = r_mem[w_rd_addr];

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // FSM
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_go_beat1) w_state_nxt = StBeat1;
      StBeat1: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Datapath, stack pointer and exception capture
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_valid    <= 1'b0;
      r_wb       <= 2'b00;
      r_alu_data <= '0;
      r_mem_data <= '0;
      r_sp       <= ADDR_W'(SP_INIT);
      r_exc      <= 2'b00;
      r_epc      <= '0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_lo       <= '0;
      r_addr     <= '0;
      r_hi_wdata <= '0;
      r_wb_hold  <= 2'b00;
      r_alu_hold <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        if (w_go_beat1) begin
          r_is_load  <= w_is_load;
          r_is_store <= w_is_store;
          r_lo       <= w_rd_data;
          r_addr     <= w_base + ADDR_W'(1);
          r_hi_wdata <= w_store_data[2*DATA_W-1:DATA_W];
          r_wb_hold  <= i_wb;
          r_alu_hold <= i_alu_data;
        end else begin
          r_valid    <= 1'b1;
          r_wb       <= w_fault ? 2'b00 : i_wb;
          r_alu_data <= i_alu_data;
          r_mem_data <= (w_is_load && !w_fault) ? 32'(w_rd_data) : '0;
        end
        // SP moves at accept so a back-to-back request sees the new value.
        if (!w_fault) begin
          if (w_is_push) begin
            r_sp <= w_sp_dec[ADDR_W-1:0];
          end else if (w_is_pop) begin
            r_sp <= w_sp_inc[ADDR_W-1:0];
          end
        end
      end else if (r_state == StBeat1) begin
        r_valid    <= 1'b1;
        r_wb       <= r_wb_hold;
        r_alu_data <= r_alu_hold;
        r_mem_data <= r_is_load ? {w_rd_data, r_lo} : '0;
      end

      // First fault wins; a clear in the same cycle lets a new fault in.
      if (w_accept && w_fault && (r_exc == 2'b00 || i_epc_clr)) begin
        r_exc <= w_exc_code;
        r_epc <= i_pc;
      end else if (i_epc_clr) begin
        r_exc <= 2'b00;
        r_epc <= '0;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_wb       = r_wb;
  assign o_alu_data = r_alu_data;
  assign o_mem_data = r_mem_data;
  assign o_sp       = r_sp;
  assign o_exc      = r_exc;
  assign o_epc      = r_epc;

endmodule

// File: tb/tb_mem_stage_seq.sv
// Directed testbench for mem_stage_seq with hand-computed expectations.
module tb_mem_stage_seq;

  logic        clk;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [1:0]  i_sp_op;
  logic        i_push_pc;
  logic        i_en32;
  logic [1:0]  i_wb;
  logic [15:0] i_alu_data;
  logic [31:0] i_wdata;
  logic [31:0] i_pc;
  logic        i_epc_clr;
  logic        o_valid;
  logic [1:0]  o_wb;
  logic [15:0] o_alu_data;
  logic [31:0] o_mem_data;
  logic [11:0] o_sp;
  logic [1:0]  o_exc;
  logic [31:0] o_epc;

  int n_pass  = 0;
  int n_total = 0;

  mem_stage_seq dut (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_op       (i_op),
    .i_sp_op    (i_sp_op),
    .i_push_pc  (i_push_pc),
    .i_en32     (i_en32),
    .i_wb       (i_wb),
    .i_alu_data (i_alu_data),
    .i_wdata    (i_wdata),
    .i_pc       (i_pc),
    .i_epc_clr  (i_epc_clr),
    .o_valid    (o_valid),
    .o_wb       (o_wb),
    .o_alu_data (o_alu_data),
    .o_mem_data (o_mem_data),
    .o_sp       (o_sp),
    .o_exc      (o_exc),
    .o_epc      (o_epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request and return #1 after the edge on which it was accepted.
  task automatic send(input logic [1:0] op, input logic [1:0] sp_op, input logic push_pc,
                      input logic en32, input logic [1:0] wb, input logic [15:0] alu,
                      input logic [31:0] wdata, input logic [31:0] pc);
    int waited;
    i_op       = op;
    i_sp_op    = sp_op;
    i_push_pc  = push_pc;
    i_en32     = en32;
    i_wb       = wb;
    i_alu_data = alu;
    i_wdata    = wdata;
    i_pc       = pc;
    i_valid    = 1'b1;
    waited     = 0;
    while (!o_ready && waited < 10) begin
      step();
      waited++;
    end
    if (!o_ready) begin
      n_total++;
      $error("FAIL ready_timeout: observed o_ready=0 expected 1 within 10 cycles");
    end
    step();
    i_valid = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_op = 2'b00; i_sp_op = 2'b00; i_push_pc = 1'b0;
    i_en32 = 1'b0; i_wb = 2'b00; i_alu_data = '0; i_wdata = '0; i_pc = '0; i_epc_clr = 1'b0;
    step();
    step();
    i_reset = 1'b0;
    step();

    // Reset state
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_sp", 32'(o_sp), 32'h0FFF);
    check("rst_exc", 32'(o_exc), 32'd0);
    check("rst_epc", o_epc, 32'd0);
    check("rst_wb", 32'(o_wb), 32'd0);
    check("rst_mdata", o_mem_data, 32'd0);

    // Push32 of PC+1
    send(2'b00, 2'b01, 1'b1, 1'b0, 2'b11, 16'h0000, 32'h0, 32'h0000_0100);
    check("push32_sp", 32'(o_sp), 32'h0FFD);
    check("push32_v1", 32'(o_valid), 32'd0);
    check("push32_rdy", 32'(o_ready), 32'd0);
    step();
    check("push32_v2", 32'(o_valid), 32'd1);
    check("push32_wb", 32'(o_wb), 32'h3);
    step();
    check("push32_vpulse", 32'(o_valid), 32'd0);

    // Pop32 reads back both words
    send(2'b00, 2'b10, 1'b0, 1'b1, 2'b01, 16'h0000, 32'h0, 32'h0000_0110);
    check("pop32_rdy", 32'(o_ready), 32'd0);
    check("pop32_sp", 32'(o_sp), 32'h0FFF);
    step();
    check("pop32_valid", 32'(o_valid), 32'd1);
    check("pop32_data", o_mem_data, 32'h0000_0101);
    check("pop32_rdy2", 32'(o_ready), 32'd1);

    // Pop16 at empty stack -> underflow
    send(2'b00, 2'b10, 1'b0, 1'b0, 2'b11, 16'h0000, 32'h0, 32'h0000_0200);
    check("unf_valid", 32'(o_valid), 32'd1);
    check("unf_exc", 32'(o_exc), 32'h3);
    check("unf_epc", o_epc, 32'h0000_0200);
    check("unf_wb", 32'(o_wb), 32'd0);
    check("unf_sp", 32'(o_sp), 32'h0FFF);
    check("unf_mdata", o_mem_data, 32'd0);

    // Second fault while sticky -> unchanged
    send(2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 16'h0FFF, 32'h0, 32'h0000_0300);
    check("sticky_valid", 32'(o_valid), 32'd1);
    check("sticky_exc", 32'(o_exc), 32'h3);
    check("sticky_epc", o_epc, 32'h0000_0200);

    // Clear
    i_epc_clr = 1'b1;
    step();
    i_epc_clr = 1'b0;
    check("clr_exc", 32'(o_exc), 32'd0);
    check("clr_epc", o_epc, 32'd0);

    // Store32 / load32
    send(2'b10, 2'b00, 1'b0, 1'b1, 2'b01, 16'h0010, 32'hDEAD_BEEF, 32'h0000_0400);
    check("st32_v1", 32'(o_valid), 32'd0);
    step();
    check("st32_v2", 32'(o_valid), 32'd1);
    check("st32_alu", 32'(o_alu_data), 32'h0010);
    send(2'b01, 2'b00, 1'b0, 1'b1, 2'b10, 16'h0010, 32'h0, 32'h0000_0404);
    step();
    check("ld32_valid", 32'(o_valid), 32'd1);
    check("ld32_data", o_mem_data, 32'hDEAD_BEEF);
    check("ld32_wb", 32'(o_wb), 32'h2);

    // Load32 at top word -> invalid address
    send(2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 16'h0FFF, 32'h0, 32'h0000_0500);
    check("inv_valid", 32'(o_valid), 32'd1);
    check("inv_exc", 32'(o_exc), 32'h1);
    check("inv_epc", o_epc, 32'h0000_0500);
    check("inv_wb", 32'(o_wb), 32'd0);

    // Clear coincident with a new fault (address beyond RAM): new fault captured
    i_epc_clr = 1'b1;
    send(2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 16'h1000, 32'h0, 32'h0000_0600);
    i_epc_clr = 1'b0;
    check("clrfault_exc", 32'(o_exc), 32'h1);
    check("clrfault_epc", o_epc, 32'h0000_0600);
    i_epc_clr = 1'b1;
    step();
    i_epc_clr = 1'b0;
    check("clr2_exc", 32'(o_exc), 32'd0);

    // Store16 then load16 back-to-back: zero-extended, new data
    send(2'b10, 2'b00, 1'b0, 1'b0, 2'b01, 16'h0030, 32'h1234_ABCD, 32'h0000_0700);
    check("st16_valid", 32'(o_valid), 32'd1);
    send(2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 16'h0030, 32'h0, 32'h0000_0704);
    check("ld16_valid", 32'(o_valid), 32'd1);
    check("ld16_data", o_mem_data, 32'h0000_ABCD);

    // Pass-through
    send(2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 16'h5A5A, 32'h0, 32'h0000_0800);
    check("pt_valid", 32'(o_valid), 32'd1);
    check("pt_alu", 32'(o_alu_data), 32'h5A5A);
    check("pt_wb", 32'(o_wb), 32'h2);
    check("pt_mdata", o_mem_data, 32'd0);
    check("pt_exc", 32'(o_exc), 32'd0);

    // Fill the stack down to SP_LIMIT-1 with push32, then one more push overflows
    for (int k = 0; k < 1024; k++) begin
      send(2'b00, 2'b01, 1'b0, 1'b1, 2'b01, 16'h0000, 32'h0, 32'h0000_1000);
      step();
    end
    check("fill_sp", 32'(o_sp), 32'h07FF);
    check("fill_exc", 32'(o_exc), 32'd0);
    send(2'b00, 2'b01, 1'b0, 1'b0, 2'b01, 16'h0000, 32'h0, 32'h0000_2000);
    check("ovf_exc", 32'(o_exc), 32'h2);
    check("ovf_epc", o_epc, 32'h0000_2000);
    check("ovf_sp", 32'(o_sp), 32'h07FF);
    check("ovf_wb", 32'(o_wb), 32'd0);

    // Reset during the second beat of a store32
    send(2'b10, 2'b00, 1'b0, 1'b1, 2'b01, 16'h0020, 32'h1111_2222, 32'h0000_3000);
    step();
    send(2'b10, 2'b00, 1'b0, 1'b1, 2'b01, 16'h0020, 32'hAAAA_BBBB, 32'h0000_3004);
    i_reset = 1'b1;
    step();
    check("abort_v1", 32'(o_valid), 32'd0);
    i_reset = 1'b0;
    step();
    check("abort_v2", 32'(o_valid), 32'd0);
    check("abort_sp", 32'(o_sp), 32'h0FFF);
    check("abort_exc", 32'(o_exc), 32'd0);
    check("abort_rdy", 32'(o_ready), 32'd1);
    send(2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 16'h0020, 32'h0, 32'h0000_3008);
    step();
    check("abort_ld_valid", 32'(o_valid), 32'd1);
    check("abort_hi_kept", 32'(o_mem_data[31:16]), 32'h1111);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
